tile_mem_bank_cfg_loader: RTL and testbench

- Configuration-bank writer that sits directly upstream of a tile's flat memory bank.
- Drives the tile's `bl[0:NUM_CELLS-1]` / `wl[0:NUM_CELLS-1]` buses, one per config cell.
- Accepts the tile bitstream as WORD_W-bit words over a valid/ready handshake.
- For each word: drives the matching BL group, applies setup, pulses the matching WL group, then holds BL.
- One instance per tile; it sequences the full 1260-cell load of the top-right tile.

---
 rtl/tile_mem_bank_cfg_loader.sv | 147 ++++++++++++++
 tb/tb_tile_mem_bank_cfg_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_mem_bank_cfg_loader.sv
// Config-bank writer for one tile: takes bitstream words over valid/ready and
// sequences BL setup, WL pulse and BL hold for each WORD_W-cell group.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | waiting for start
// WAIT_WORD | cfg_ready high, waiting for the next word
// SETUP     | BL driven with the word, WL low
// PULSE     | WL group of the current word high
// HOLD      | WL low, BL still held
// DONE      | one-cycle done pulse, then back to IDLE
module tile_mem_bank_cfg_loader #(
  parameter int NUM_CELLS = 1260,
  parameter int WORD_W    = 20,
  parameter int WL_SETUP  = 1,
  parameter int WL_PULSE  = 2,
  parameter int WL_HOLD   = 1,
  localparam int NUM_WORDS = (NUM_CELLS + WORD_W - 1) / WORD_W,
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WORD_W-1:0]    cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [0:NUM_CELLS-1] bl,
  output logic [0:NUM_CELLS-1] wl,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     word_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [7:0]       SETUP_LD = 8'(WL_SETUP - 1);
  localparam logic [7:0]       PULSE_LD = 8'(WL_PULSE - 1);
  localparam logic [7:0]       HOLD_LD  = 8'(WL_HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t               state;
  logic [7:0]           ph_cnt;
  logic [0:NUM_CELLS-1] bl_word;
  logic [0:NUM_CELLS-1] wl_grp;

  // Word bit WORD_W-1-k lands on cell g*WORD_W+k; cells past NUM_CELLS never exist.
  always_comb begin
    bl_word = '0;
    wl_grp  = '0;
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (word_idx == IDX_W'(c / WORD_W)) begin
        bl_word[c] = cfg_data[WORD_W-1-(c % WORD_W)];
        wl_grp[c]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ph_cnt    <= 8'd0;
      bl        <= '0;
      wl        <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      word_idx  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        ph_cnt    <= 8'd0;
        bl        <= '0;
        wl        <= '0;
        cfg_ready <= 1'b0;
        busy      <= 1'b0;
        word_idx  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_WAIT_WORD;
              word_idx  <= '0;
              busy      <= 1'b1;
              cfg_ready <= 1'b1;
            end
          end
          S_WAIT_WORD: begin
            if (cfg_valid && cfg_ready) begin
              state     <= S_SETUP;
              bl        <= bl_word;
              cfg_ready <= 1'b0;
              ph_cnt    <= SETUP_LD;
            end
          end
          S_SETUP: begin
            if (ph_cnt == 8'd0) begin
              state  <= S_PULSE;
              wl     <= wl_grp;
              ph_cnt <= PULSE_LD;
            end else begin
              ph_cnt <= ph_cnt - 8'd1;
            end
          end
          S_PULSE: begin
            if (ph_cnt == 8'd0) begin
              state  <= S_HOLD;
              wl     <= '0;
              ph_cnt <= HOLD_LD;
            end else begin
              ph_cnt <= ph_cnt - 8'd1;
            end
          end
          S_HOLD: begin
            if (ph_cnt == 8'd0) begin
              if (word_idx == LAST_IDX) begin
                state <= S_DONE;
                bl    <= '0;
                done  <= 1'b1;
              end else begin
                state     <= S_WAIT_WORD;
                word_idx  <= word_idx + 1'b1;
                cfg_ready <= 1'b1;
              end
            end else begin
              ph_cnt <= ph_cnt - 8'd1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tile_mem_bank_cfg_loader.sv
// Directed bench: default tile, a 30-cell partial-word tile and a tile with
// stretched setup/pulse/hold timing, all checked against hand-computed values.
module tb_tile_mem_bank_cfg_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // default tile
  logic              start = 0, abort = 0, cfg_valid = 0, cfg_ready, busy, done;
  logic [19:0]       cfg_data = '0;
  logic [0:1259]     bl, wl;
  logic [5:0]        word_idx;

  // partial last word tile
  logic              p_start = 0, p_abort = 0, p_valid = 0, p_ready, p_busy, p_done;
  logic [19:0]       p_data = '0;
  logic [0:29]       p_bl, p_wl;
  logic [0:0]        p_idx;

  // stretched timing tile
  logic              t_start = 0, t_abort = 0, t_valid = 0, t_ready, t_busy, t_done;
  logic [19:0]       t_data = '0;
  logic [0:1259]     t_bl, t_wl;
  logic [5:0]        t_idx;

  tile_mem_bank_cfg_loader u_dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .bl(bl), .wl(wl), .busy(busy), .done(done), .word_idx(word_idx));

  tile_mem_bank_cfg_loader #(.NUM_CELLS(30)) u_part (
    .clk(clk), .reset(rst_n), .start(p_start), .abort(p_abort),
    .cfg_data(p_data), .cfg_valid(p_valid), .cfg_ready(p_ready),
    .bl(p_bl), .wl(p_wl), .busy(p_busy), .done(p_done), .word_idx(p_idx));

  tile_mem_bank_cfg_loader #(.WL_SETUP(3), .WL_PULSE(4), .WL_HOLD(2)) u_tim (
    .clk(clk), .reset(rst_n), .start(t_start), .abort(t_abort),
    .cfg_data(t_data), .cfg_valid(t_valid), .cfg_ready(t_ready),
    .bl(t_bl), .wl(t_wl), .busy(t_busy), .done(t_done), .word_idx(t_idx));

  always @(posedge clk) if (done) done_seen <= done_seen + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pat(input int w);
    return (w == 0) ? 20'hA5A5A : 20'(w * 32'h1F3D5 + 32'h00C31);
  endfunction

  // Entered at the negedge of a WAIT_WORD cycle; leaves at the negedge after HOLD.
  task automatic do_word(input int w, input logic [19:0] d);
    logic [19:0] g;
    chk("wait_ready", cfg_ready, 1);
    chk("wait_idx", word_idx, w);
    cfg_data  = d;
    cfg_valid = 1;
    @(negedge clk);
    g = bl[w*20 +: 20];
    chk("setup_bl", g, d);
    chk("setup_bl_only", $countones(bl), $countones(d));
    chk("setup_wl", $countones(wl), 0);
    cfg_data = ~d;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      g = wl[w*20 +: 20];
      chk("pulse_wl_grp", g, 20'hFFFFF);
      chk("pulse_wl_cnt", $countones(wl), 20);
      g = bl[w*20 +: 20];
      chk("pulse_bl", g, d);
    end
    @(negedge clk);
    chk("hold_wl", $countones(wl), 0);
    g = bl[w*20 +: 20];
    chk("hold_bl", g, d);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int rise[4], fall[4], blch[4];
    int nr, nf, nb, viol, prev_cnt, cur_cnt;
    logic [0:1259] prev_bl;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", word_idx, 0);
    chk("rst_bl", $countones(bl), 0);
    chk("rst_wl", $countones(wl), 0);
    rst_n = 1;
    @(negedge clk);

    // full load, valid held high
    start = 1;
    @(negedge clk);
    start = 0;
    c0 = cyc;
    chk("start_busy", busy, 1);
    for (int w = 0; w < 63; w++) do_word(w, pat(w));
    chk("full_done", done, 1);
    chk("full_busy_in_done", busy, 1);
    chk("full_cycles", cyc - c0, 315);
    chk("done_bl", $countones(bl), 0);
    chk("done_wl", $countones(wl), 0);
    cfg_valid = 0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_fall", busy, 0);
    chk("idle_ready", cfg_ready, 0);
    chk("done_count", done_seen, 1);

    // stall in WAIT_WORD, then abort during word 5 PULSE
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_ready", cfg_ready, 1);
      chk("stall_wl", $countones(wl), 0);
      @(negedge clk);
    end
    for (int w = 0; w < 5; w++) do_word(w, pat(w + 40));
    chk("w5_idx", word_idx, 5);
    cfg_data  = pat(5);
    cfg_valid = 1;
    repeat (2) @(negedge clk);
    chk("w5_pulse", $countones(wl), 20);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_wl", $countones(wl), 0);
    chk("abort_bl", $countones(bl), 0);
    chk("abort_busy", busy, 0);
    chk("abort_idx", word_idx, 0);
    chk("abort_ready", cfg_ready, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_seen, 1);

    // abort wins over a handshake in the same cycle
    start = 1;
    @(negedge clk);
    start = 0;
    cfg_data = 20'hFFFFF;
    abort = 1;
    @(negedge clk);
    abort = 0;
    cfg_valid = 0;
    chk("abort_prio_bl", $countones(bl), 0);
    chk("abort_prio_busy", busy, 0);
    @(negedge clk);
    chk("abort_prio_wl", $countones(wl), 0);

    // async reset mid-pulse
    start = 1;
    @(negedge clk);
    start = 0;
    cfg_data  = pat(7);
    cfg_valid = 1;
    repeat (2) @(negedge clk);
    chk("pre_rst_pulse", $countones(wl), 20);
    #1 rst_n = 0;
    #1;
    chk("async_rst_wl", $countones(wl), 0);
    chk("async_rst_bl", $countones(bl), 0);
    chk("async_rst_busy", busy, 0);
    cfg_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    do_word(0, 20'h0F0F0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    cfg_valid = 0;

    // 30-cell tile: second word only covers cells 20..29
    p_data  = 20'h12345;
    p_valid = 1;
    p_start = 1;
    @(negedge clk);
    p_start = 0;
    @(negedge clk);
    chk("part_bl0", p_bl[0:19], 20'h12345);
    chk("part_bl0_cnt", $countones(p_bl), 7);
    @(negedge clk);
    chk("part_wl0", $countones(p_wl), 20);
    repeat (3) @(negedge clk);
    chk("part_idx1", p_idx, 1);
    chk("part_ready1", p_ready, 1);
    p_data = 20'hFFFFF;
    @(negedge clk);
    chk("part_bl1", p_bl[20:29], 10'h3FF);
    chk("part_bl1_cnt", $countones(p_bl), 10);
    @(negedge clk);
    chk("part_wl1", p_wl[20:29], 10'h3FF);
    chk("part_wl1_cnt", $countones(p_wl), 10);
    repeat (2) @(negedge clk);
    chk("part_hold_wl", $countones(p_wl), 0);
    chk("part_hold_nodone", p_done, 0);
    @(negedge clk);
    chk("part_done", p_done, 1);
    p_valid = 0;

    // stretched timing: SETUP 3, PULSE 4, HOLD 2
    foreach (rise[i]) begin rise[i] = -100; fall[i] = -100; blch[i] = -100; end
    nr = 0; nf = 0; nb = 0; viol = 0;
    t_data  = 20'hC3C3C;
    t_valid = 1;
    t_start = 1;
    @(negedge clk);
    t_start  = 0;
    prev_cnt = $countones(t_wl);
    prev_bl  = t_bl;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      cur_cnt = $countones(t_wl);
      if (prev_cnt == 0 && cur_cnt > 0 && nr < 4) begin rise[nr] = n; nr++; end
      if (prev_cnt > 0 && cur_cnt == 0 && nf < 4) begin fall[nf] = n; nf++; end
      if (t_bl != prev_bl && nb < 4) begin blch[nb] = n; nb++; end
      if (cur_cnt != prev_cnt && t_bl != prev_bl) viol++;
      prev_cnt = cur_cnt;
      prev_bl  = t_bl;
    end
    chk("tim_setup", rise[0] - blch[0], 3);
    chk("tim_pulse", fall[0] - rise[0], 4);
    chk("tim_spacing", rise[1] - rise[0], 10);
    chk("tim_hold", blch[1] - fall[0], 3);
    chk("tim_pulse2", fall[1] - rise[1], 4);
    chk("tim_wl_bl_same_edge", viol, 0);
    t_abort = 1;
    @(negedge clk);
    t_abort = 0;
    t_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
